// File: rtl/pcpi_arb_pkg.sv
// Shared definitions for the two-requester PCPI divide arbiter.
package pcpi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } arb_state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/pcpi_div_decode.sv
// Per-requester decoder: flags the DIV/DIVU/REM/REMU half of the RV32M group.
module pcpi_div_decode
  import pcpi_arb_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  input  logic       funct3_msb,
  output logic       is_div
);

  // funct3[2] separates the divide/remainder ops from the multiply ops
  assign is_div = (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV) && funct3_msb;

endmodule

// File: rtl/pcpi_div_arbiter.sv
// Shares one PCPI divider between two PCPI requesters with round-robin
// arbitration; the result is returned only to the requester that issued it.
module pcpi_div_arbiter
  import pcpi_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NREQ-1:0]     pcpi_valid_i,
  input  logic [NREQ*32-1:0]  pcpi_insn_i,
  input  logic [NREQ*32-1:0]  pcpi_rs1_i,
  input  logic [NREQ*32-1:0]  pcpi_rs2_i,
  output logic [NREQ-1:0]     pcpi_wr_o,
  output logic [NREQ*32-1:0]  pcpi_rd_o,
  output logic [NREQ-1:0]     pcpi_wait_o,
  output logic [NREQ-1:0]     pcpi_ready_o,
  output logic                div_valid,
  output logic [31:0]         div_insn,
  output logic [31:0]         div_rs1,
  output logic [31:0]         div_rs2,
  input  logic                div_wr,
  input  logic [31:0]         div_rd,
  input  logic                div_wait,
  input  logic                div_ready,
  output logic                busy,
  output logic                grant
);

  // The round-robin and one-bit grant only make sense for a pair of requesters
  if (NREQ != 2) begin : g_nreq_check
    $error("pcpi_div_arbiter supports exactly two requesters");
  end

  // Downstream busy is observed only; the handshake completes on div_ready
  logic div_wait_unused;
  assign div_wait_unused = div_wait;

  logic [31:0]     insn_a [NREQ];
  logic [31:0]     rs1_a  [NREQ];
  logic [31:0]     rs2_a  [NREQ];
  logic [NREQ-1:0] is_div;
  logic [NREQ-1:0] req;

  arb_state_e      state_q, state_d;
  logic            grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            div_valid_q, div_valid_d;
  logic [31:0]     op_insn_q, op_insn_d;
  logic [31:0]     op_rs1_q, op_rs1_d;
  logic [31:0]     op_rs2_q, op_rs2_d;
  logic            abort_q, abort_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic [NREQ-1:0] wr_q, wr_d;
  logic [31:0]     rd_q [NREQ];
  logic [31:0]     rd_d [NREQ];
  logic            win;
  logic            abort_now;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign insn_a[gi] = pcpi_insn_i[gi*32 +: 32];
      assign rs1_a[gi]  = pcpi_rs1_i[gi*32 +: 32];
      assign rs2_a[gi]  = pcpi_rs2_i[gi*32 +: 32];

      pcpi_div_decode u_decode (
        .opcode     (insn_a[gi][6:0]),
        .funct7     (insn_a[gi][31:25]),
        .funct3_msb (insn_a[gi][14]),
        .is_div     (is_div[gi])
      );

      // Wait is raised as soon as a divide is presented, even while the
      // other requester is being served, so neither core times out.
      assign req[gi]          = pcpi_valid_i[gi] & is_div[gi];
      assign pcpi_wait_o[gi]  = req[gi];
      assign pcpi_ready_o[gi] = ready_q[gi];
      assign pcpi_wr_o[gi]    = wr_q[gi];
      assign pcpi_rd_o[gi*32 +: 32] = rd_q[gi];
    end
  endgenerate

  assign div_valid = div_valid_q;
  assign div_insn  = op_insn_q;
  assign div_rs1   = op_rs1_q;
  assign div_rs2   = op_rs2_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

  // Next-state and registered-output computation for the arbitration FSM
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    div_valid_d = div_valid_q;
    op_insn_d   = op_insn_q;
    op_rs1_d    = op_rs1_q;
    op_rs2_d    = op_rs2_q;
    abort_d     = abort_q;
    ready_d     = '0;
    wr_d        = '0;
    for (int i = 0; i < NREQ; i++) rd_d[i] = '0;
    win         = ~grant_q;
    // A granted requester that lets go of valid at any point in ISSUE
    // forfeits its result; the divider still runs to completion.
    abort_now   = abort_q | ~pcpi_valid_i[grant_q];

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          // On a tie the requester that was not served last wins
          win         = (&req) ? ~grant_q : req[1];
          grant_d     = win;
          op_insn_d   = insn_a[win];
          op_rs1_d    = rs1_a[win];
          op_rs2_d    = rs2_a[win];
          abort_d     = 1'b0;
          div_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        abort_d = abort_now;
        if (div_ready) begin
          div_valid_d = 1'b0;
          state_d     = RESPOND;
          if (!abort_now) begin
            ready_d[grant_q] = 1'b1;
            wr_d[grant_q]    = div_wr;
            rd_d[grant_q]    = div_rd;
          end
        end
      end
      RESPOND: begin
        // Result strobes clear by default; one idle cycle precedes the next grant
        abort_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        div_valid_d = 1'b0;
      end
    endcase
  end

  // All arbiter state, including the registered PCPI and divider outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant_q     <= 1'b1;
      busy_q      <= 1'b0;
      div_valid_q <= 1'b0;
      op_insn_q   <= '0;
      op_rs1_q    <= '0;
      op_rs2_q    <= '0;
      abort_q     <= 1'b0;
      ready_q     <= '0;
      wr_q        <= '0;
      for (int i = 0; i < NREQ; i++) rd_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      div_valid_q <= div_valid_d;
      op_insn_q   <= op_insn_d;
      op_rs1_q    <= op_rs1_d;
      op_rs2_q    <= op_rs2_d;
      abort_q     <= abort_d;
      ready_q     <= ready_d;
      wr_q        <= wr_d;
      for (int i = 0; i < NREQ; i++) rd_q[i] <= rd_d[i];
    end
  end

endmodule

// File: tb/tb_pcpi_div_arbiter.sv
// Directed bench for pcpi_div_arbiter: a latency-3 divider model downstream,
// queue-driven requesters upstream, and a per-cycle transaction-level model.
`timescale 1ns/1ps
module tb_pcpi_div_arbiter;

  localparam int DIV_LAT = 3;

  logic        clk;
  logic        resetn;
  logic [1:0]  pcpi_valid_i;
  logic [63:0] pcpi_insn_i, pcpi_rs1_i, pcpi_rs2_i;
  logic [1:0]  pcpi_wr_o, pcpi_wait_o, pcpi_ready_o;
  logic [63:0] pcpi_rd_o;
  logic        div_valid, div_wr, div_wait, div_ready;
  logic [31:0] div_insn, div_rs1, div_rs2, div_rd;
  logic        busy, grant;

  pcpi_div_arbiter #(.NREQ(2)) dut (
    .clk(clk), .resetn(resetn),
    .pcpi_valid_i(pcpi_valid_i), .pcpi_insn_i(pcpi_insn_i),
    .pcpi_rs1_i(pcpi_rs1_i), .pcpi_rs2_i(pcpi_rs2_i),
    .pcpi_wr_o(pcpi_wr_o), .pcpi_rd_o(pcpi_rd_o),
    .pcpi_wait_o(pcpi_wait_o), .pcpi_ready_o(pcpi_ready_o),
    .div_valid(div_valid), .div_insn(div_insn), .div_rs1(div_rs1), .div_rs2(div_rs2),
    .div_wr(div_wr), .div_rd(div_rd), .div_wait(div_wait), .div_ready(div_ready),
    .busy(busy), .grant(grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] insn; logic [31:0] rs1; logic [31:0] rs2; } op_t;
  typedef struct { int idx; logic [31:0] rd; logic wr; } txn_t;

  op_t  rq0[$];
  op_t  rq1[$];
  txn_t log_q[$];
  bit   done0, done1;
  int   n_cmp = 0;
  int   n_bad = 0;

  // model state
  bit          m_inflight, m_resp, m_resp_ok, m_resp_wr, m_aborted;
  int          m_owner;
  logic [31:0] m_resp_rd, m_op_insn, m_op_rs1, m_op_rs2;
  bit          prev_dv, had_op;
  int          low_run;

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    logic [31:0] w;
    w = {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    return w;
  endfunction

  function automatic op_t mk_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.insn = mk_insn(f3);
    o.rs1  = a;
    o.rs2  = b;
    return o;
  endfunction

  function automatic logic spec_is_div(input logic [31:0] insn);
    return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) && insn[14];
  endfunction

  // RISC-V M semantics for the divide group, by plain arithmetic
  function automatic logic [31:0] ref_result(input logic [31:0] insn, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (insn[13:12])
      2'b00: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin q = sa / sb; r = q[31:0]; end
      end
      2'b01:   r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'b10: begin
        if (b == 32'd0) r = a;
        else begin q = sa % sb; r = q[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream divider: completes DIV_LAT edges after valid is first seen
  initial begin
    int cnt;
    cnt = 0;
    div_ready = 1'b0; div_wr = 1'b0; div_rd = '0; div_wait = 1'b0;
    forever begin
      @(posedge clk); #1;
      div_ready = 1'b0;
      div_wr    = 1'b0;
      if (!resetn || !div_valid) cnt = 0;
      else begin
        cnt++;
        if (cnt == DIV_LAT) begin
          div_ready = 1'b1;
          div_wr    = 1'b1;
          div_rd    = ref_result(div_insn, div_rs1, div_rs2);
        end
      end
      div_wait = (cnt != 0) && !div_ready;
    end
  end

  // Requesters: present the head of each queue until it is answered
  initial begin
    pcpi_valid_i = '0; pcpi_insn_i = '0; pcpi_rs1_i = '0; pcpi_rs2_i = '0;
    forever begin
      @(posedge clk); #1;
      if (done0) begin done0 = 0; if (rq0.size() > 0) void'(rq0.pop_front()); end
      if (done1) begin done1 = 0; if (rq1.size() > 0) void'(rq1.pop_front()); end
      if (rq0.size() > 0) begin
        pcpi_valid_i[0] = 1'b1;
        pcpi_insn_i[31:0] = rq0[0].insn; pcpi_rs1_i[31:0] = rq0[0].rs1; pcpi_rs2_i[31:0] = rq0[0].rs2;
      end else pcpi_valid_i[0] = 1'b0;
      if (rq1.size() > 0) begin
        pcpi_valid_i[1] = 1'b1;
        pcpi_insn_i[63:32] = rq1[0].insn; pcpi_rs1_i[63:32] = rq1[0].rs1; pcpi_rs2_i[63:32] = rq1[0].rs2;
      end else pcpi_valid_i[1] = 1'b0;
    end
  end

  // Per-cycle compare against the transaction-level model
  initial begin
    logic [1:0] exp_ready;
    txn_t t;
    m_owner = 1; m_inflight = 0; m_resp = 0; m_resp_ok = 0; m_resp_wr = 0; m_aborted = 0;
    m_resp_rd = '0; m_op_insn = '0; m_op_rs1 = '0; m_op_rs2 = '0;
    prev_dv = 0; had_op = 0; low_run = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_owner = 1; m_inflight = 0; m_resp = 0; m_aborted = 0;
        had_op = 0; low_run = 0;
      end
      for (int i = 0; i < 2; i++)
        chk($sformatf("wait%0d", i), pcpi_wait_o[i],
            pcpi_valid_i[i] && spec_is_div(pcpi_insn_i[i*32 +: 32]));
      chk("div_valid", div_valid, m_inflight);
      chk("busy", busy, m_inflight || m_resp);
      chk("grant", grant, m_owner[0]);
      if (m_inflight) begin
        chk("div_insn", div_insn, m_op_insn);
        chk("div_rs1", div_rs1, m_op_rs1);
        chk("div_rs2", div_rs2, m_op_rs2);
      end
      exp_ready = (m_resp && m_resp_ok) ? (2'b01 << m_owner) : 2'b00;
      chk("ready", pcpi_ready_o, exp_ready);
      chk("wr", pcpi_wr_o, m_resp_wr ? exp_ready : 2'b00);
      if (exp_ready != 2'b00) chk("rd", pcpi_rd_o[m_owner*32 +: 32], m_resp_rd);
      chk("rd_other", pcpi_rd_o[(1-m_owner)*32 +: 32], 0);
      if (div_valid && !prev_dv && had_op) chk("div_valid_gap>=2", low_run >= 2, 1);
      if (div_valid) begin low_run = 0; had_op = 1; end else low_run++;
      prev_dv = div_valid;
      for (int i = 0; i < 2; i++) begin
        if (pcpi_ready_o[i]) begin
          t.idx = i; t.rd = pcpi_rd_o[i*32 +: 32]; t.wr = pcpi_wr_o[i];
          log_q.push_back(t);
          $display("txn: requester %0d rd=0x%08h wr=%0b t=%0t", i, t.rd, t.wr, $time);
          if (i == 0) done0 = 1; else done1 = 1;
        end
      end
      // predict the cycle after the coming edge
      if (resetn) begin
        if (m_inflight) begin
          if (!pcpi_valid_i[m_owner]) m_aborted = 1;
          if (div_ready) begin
            m_inflight = 0; m_resp = 1; m_resp_ok = !m_aborted;
            m_resp_wr = div_wr; m_resp_rd = div_rd;
          end
        end else if (m_resp) begin
          m_resp = 0;
        end else begin
          logic [1:0] rq;
          for (int i = 0; i < 2; i++)
            rq[i] = pcpi_valid_i[i] && spec_is_div(pcpi_insn_i[i*32 +: 32]);
          if (rq != 2'b00) begin
            m_owner    = (rq == 2'b11) ? 1 - m_owner : (rq[1] ? 1 : 0);
            m_inflight = 1; m_aborted = 0;
            m_op_insn  = pcpi_insn_i[m_owner*32 +: 32];
            m_op_rs1   = pcpi_rs1_i[m_owner*32 +: 32];
            m_op_rs2   = pcpi_rs2_i[m_owner*32 +: 32];
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  task automatic wait_log(input int n, input string name);
    int k;
    k = 0;
    while (log_q.size() < n && k < 200) begin @(negedge clk); k++; end
    chk({name, "_responses_arrived"}, log_q.size() >= n, 1);
    repeat (6) @(negedge clk);
    chk({name, "_response_count"}, log_q.size(), n);
  endtask

  task automatic wait_dv(input string name);
    int k;
    k = 0;
    while (!div_valid && k < 50) begin @(negedge clk); k++; end
    chk({name, "_div_valid_seen"}, div_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;

    // 1: single DIV 20 / 3 from requester 0
    do_reset();
    log_q.delete();
    rq0.push_back(mk_op(3'b100, 32'd20, 32'd3));
    @(posedge clk); #2;
    chk("t1_wait0_same_cycle", pcpi_wait_o[0], 1);
    chk("t1_div_valid_before_edge", div_valid, 0);
    @(posedge clk); #2;
    chk("t1_div_valid_after_1_edge", div_valid, 1);
    wait_log(1, "t1");
    if (log_q.size() >= 1) begin
      chk("t1_idx", log_q[0].idx, 0);
      chk("t1_rd", log_q[0].rd, 32'd6);
      chk("t1_wr", log_q[0].wr, 1);
    end

    // 2: simultaneous REM -20 % 3 (r0) and DIVU 0xFFFFFFFF / 2 (r1) after reset
    do_reset();
    log_q.delete();
    rq0.push_back(mk_op(3'b110, 32'hFFFF_FFEC, 32'd3));
    rq1.push_back(mk_op(3'b101, 32'hFFFF_FFFF, 32'd2));
    wait_log(2, "t2");
    if (log_q.size() >= 2) begin
      chk("t2_first_idx", log_q[0].idx, 0);
      chk("t2_first_rd", log_q[0].rd, 32'hFFFF_FFFE);
      chk("t2_second_idx", log_q[1].idx, 1);
      chk("t2_second_rd", log_q[1].rd, 32'h7FFF_FFFF);
    end

    // 3: round-robin, both requesters streaming REMU 20 % 3
    log_q.delete();
    for (int k = 0; k < 3; k++) begin
      rq0.push_back(mk_op(3'b111, 32'd20, 32'd3));
      rq1.push_back(mk_op(3'b111, 32'd20, 32'd3));
    end
    wait_log(6, "t3");
    for (int k = 0; k < 6 && k < log_q.size(); k++) begin
      chk($sformatf("t3_grant_%0d", k), log_q[k].idx, k % 2);
      chk($sformatf("t3_rd_%0d", k), log_q[k].rd, 32'd2);
    end

    // 4: r1 MUL is ignored while r0 DIV 20 / 0 is served
    log_q.delete();
    rq1.push_back(mk_op(3'b000, 32'd5, 32'd7));
    rq0.push_back(mk_op(3'b100, 32'd20, 32'd0));
    @(posedge clk); #2;
    chk("t4_mul_no_wait", pcpi_wait_o[1], 0);
    chk("t4_div_wait", pcpi_wait_o[0], 1);
    wait_log(1, "t4");
    if (log_q.size() >= 1) begin
      chk("t4_idx", log_q[0].idx, 0);
      chk("t4_rd", log_q[0].rd, 32'hFFFF_FFFF);
    end
    rq1.delete();
    repeat (3) @(negedge clk);

    // 5: r0 abandons its op mid-ISSUE, then r1 DIVU 100 / 7
    log_q.delete();
    rq0.push_back(mk_op(3'b100, 32'd100, 32'd7));
    wait_dv("t5");
    rq0.delete();
    rq1.push_back(mk_op(3'b101, 32'd100, 32'd7));
    wait_log(1, "t5");
    if (log_q.size() >= 1) begin
      chk("t5_idx", log_q[0].idx, 1);
      chk("t5_rd", log_q[0].rd, 32'd14);
    end

    // 6: reset pulse mid-ISSUE, then DIV 20 / -3 completes afresh
    log_q.delete();
    rq0.push_back(mk_op(3'b100, 32'd20, 32'hFFFF_FFFD));
    wait_dv("t6");
    @(negedge clk); #2 resetn = 1'b0;
    #1;
    chk("t6_div_valid_async_low", div_valid, 0);
    chk("t6_busy_low", busy, 0);
    chk("t6_grant_reset", grant, 1);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    wait_log(1, "t6");
    if (log_q.size() >= 1) begin
      chk("t6_idx", log_q[0].idx, 0);
      chk("t6_rd", log_q[0].rd, 32'hFFFF_FFFA);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
